text_buf_ctrl: RTL and testbench

TEXT_BUF_CTRL -- requirements
Module: text_buf_ctrl

---
 rtl/text_buf_ctrl.sv | 145 ++++++++++++++
 tb/tb_text_buf_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/text_buf_ctrl.sv
// rtl/text_buf_ctrl.sv - 16x16 text character store with draw read port and WRITE/CLEAR/SCROLL command FSM
module text_buf_ctrl #(
  parameter int unsigned CHARS_IN_LINE   = 16,
  parameter int unsigned NUMBER_OF_LINES = 16,
  parameter logic [7:0]  FILL_CHAR       = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_xy,
  output logic [7:0] char_code,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_xy,
  input  logic [7:0] cmd_char,
  output logic       cmd_done
);

  localparam logic [3:0] LAST_COL   = 4'(CHARS_IN_LINE - 1);
  localparam logic [3:0] LAST_LINE  = 4'(NUMBER_OF_LINES - 1);
  localparam bit         HAS_SCROLL = (NUMBER_OF_LINES > 1);

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_CLEAR  = 2'd1;
  localparam logic [1:0] OP_SCROLL = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCR_RD, S_SCR_WR, S_FILL} state_t;

  state_t     state, state_nxt;
  logic [7:0] mem [0:255];
  logic [7:0] cnt, cnt_nxt, cnt_step;
  logic [7:0] rd_data;
  logic       done_nxt;
  logic       mem_we;
  logic [7:0] mem_waddr, mem_wdata;
  logic       accept, col_last, cell_last;

  // cnt is {line, col}; stepping skips unused columns so only used cells are visited
  assign accept    = cmd_valid && (state == S_IDLE);
  assign col_last  = (cnt[3:0] == LAST_COL);
  assign cell_last = col_last && (cnt[7:4] == LAST_LINE);
  assign cnt_step  = col_last ? {cnt[7:4] + 4'd1, 4'd0} : cnt + 8'd1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_CLEAR)       state_nxt = S_CLEAR;
          else if (cmd_op == OP_SCROLL) state_nxt = HAS_SCROLL ? S_SCR_RD : S_FILL;
        end
      end
      S_CLEAR:  if (cell_last) state_nxt = S_IDLE;
      S_SCR_RD: state_nxt = S_SCR_WR;
      S_SCR_WR: state_nxt = cell_last ? S_FILL : S_SCR_RD;
      S_FILL:   if (col_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Store write port, counter update and completion pulse per state
  always_comb begin
    cmd_ready = (state == S_IDLE);
    mem_we    = 1'b0;
    mem_waddr = cnt;
    mem_wdata = FILL_CHAR;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WRITE: begin
              mem_we    = (cmd_xy[3:0] <= LAST_COL) && (cmd_xy[7:4] <= LAST_LINE);
              mem_waddr = cmd_xy;
              mem_wdata = cmd_char;
              done_nxt  = 1'b1;
            end
            OP_CLEAR:  cnt_nxt = 8'h00;
            OP_SCROLL: cnt_nxt = HAS_SCROLL ? 8'h10 : {LAST_LINE, 4'd0};
            default:   done_nxt = 1'b1;
          endcase
        end
      end
      S_CLEAR: begin
        mem_we = 1'b1;
        if (cell_last) begin
          cnt_nxt  = 8'h00;
          done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_step;
        end
      end
      S_SCR_WR: begin
        // source cell was latched in SCR_RD; destination is the same column one line up
        mem_we    = 1'b1;
        mem_waddr = {cnt[7:4] - 4'd1, cnt[3:0]};
        mem_wdata = rd_data;
        cnt_nxt   = cell_last ? {LAST_LINE, 4'd0} : cnt_step;
      end
      S_FILL: begin
        mem_we = 1'b1;
        if (col_last) begin
          cnt_nxt  = 8'h00;
          done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Cell counter, done pulse and scroll source latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 8'h00;
      cmd_done <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      cnt      <= cnt_nxt;
      cmd_done <= done_nxt;
      if (state == S_SCR_RD) rd_data <= mem[cnt];
    end
  end

  // Store write; contents are never reset
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  // Draw read port: one-cycle latency, read-first against the internal write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) char_code <= 8'h00;
    else     char_code <= mem[char_xy];
  end

endmodule

// File: tb/tb_text_buf_ctrl.sv
// tb/tb_text_buf_ctrl.sv - directed self-checking bench for text_buf_ctrl
module tb_text_buf_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_xy, char_code, cmd_xy, cmd_char;
  logic       cmd_valid, cmd_ready, cmd_done;
  logic [1:0] cmd_op;
  logic [7:0] s_char_xy, s_char_code, s_cmd_xy, s_cmd_char;
  logic       s_cmd_valid, s_cmd_ready, s_cmd_done;
  logic [1:0] s_cmd_op;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  text_buf_ctrl u_dut (
    .clk(clk), .rst(rst), .char_xy(char_xy), .char_code(char_code),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_xy(cmd_xy), .cmd_char(cmd_char), .cmd_done(cmd_done)
  );

  text_buf_ctrl #(.CHARS_IN_LINE(4), .NUMBER_OF_LINES(2)) u_small (
    .clk(clk), .rst(rst), .char_xy(s_char_xy), .char_code(s_char_code),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(s_cmd_op),
    .cmd_xy(s_cmd_xy), .cmd_char(s_cmd_char), .cmd_done(s_cmd_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] xy, input logic [7:0] ch);
    cmd_op = op; cmd_xy = xy; cmd_char = ch; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic s_cmd(input logic [1:0] op, input logic [7:0] xy, input logic [7:0] ch);
    s_cmd_op = op; s_cmd_xy = xy; s_cmd_char = ch; s_cmd_valid = 1'b1;
    tick();
    s_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!cmd_ready && n < 2000) begin tick(); n++; end
  endtask

  task automatic s_wait_idle(output int n);
    n = 0;
    while (!s_cmd_ready && n < 2000) begin tick(); n++; end
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string tag);
    char_xy = a;
    tick();
    check($sformatf("%s[%02h]", tag, a), char_code, e);
  endtask

  task automatic s_rd(input logic [7:0] a, input logic [7:0] e, input string tag);
    s_char_xy = a;
    tick();
    check($sformatf("%s[%02h]", tag, a), s_char_code, e);
  endtask

  initial begin
    int n, dn, rdy;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd3; cmd_xy = 8'h00; cmd_char = 8'h00; char_xy = 8'h00;
    s_cmd_valid = 1'b0; s_cmd_op = 2'd3; s_cmd_xy = 8'h00; s_cmd_char = 8'h00; s_char_xy = 8'h00;
    repeat (3) tick();
    check("rst_char_code", char_code, 8'h00);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_done", cmd_done, 1'b0);
    check("s_rst_ready", s_cmd_ready, 1'b1);
    rst = 1'b0;
    tick();

    // CLEAR with defaults
    cmd(2'd1, 8'h00, 8'h00);
    wait_idle(n);
    check("clear_busy", n, 256);
    check("clear_done", cmd_done, 1'b1);
    tick();
    check("clear_done_once", cmd_done, 1'b0);
    for (int i = 0; i < 256; i++) rd(8'(i), 8'h20, "clear");

    // WRITE and read back, then read-first on a colliding write
    cmd(2'd0, 8'h3A, 8'h41);
    check("wr_ready", cmd_ready, 1'b1);
    check("wr_done", cmd_done, 1'b1);
    tick();
    check("wr_done_once", cmd_done, 1'b0);
    rd(8'h3A, 8'h41, "wr");
    char_xy = 8'h3A;
    cmd(2'd0, 8'h3A, 8'h42);
    check("rdfirst_old", char_code, 8'h41);
    tick();
    check("rdfirst_new", char_code, 8'h42);

    // line n holds n, then SCROLL
    for (int i = 0; i < 256; i++) cmd(2'd0, 8'(i), 8'(i >> 4));
    cmd(2'd2, 8'h00, 8'h00);
    wait_idle(n);
    check("scroll_busy", n, 496);
    check("scroll_done", cmd_done, 1'b1);
    for (int i = 0; i < 256; i++)
      rd(8'(i), ((i >> 4) < 15) ? 8'((i >> 4) + 1) : 8'h20, "scroll");

    // column c holds c everywhere; sweep the draw port during SCROLL with a WRITE held
    for (int i = 0; i < 256; i++) cmd(2'd0, 8'(i), 8'(i & 15));
    char_xy = 8'h00;
    cmd_op = 2'd2; cmd_valid = 1'b1;
    tick();
    cmd_op = 2'd0; cmd_xy = 8'h00; cmd_char = 8'hEE;
    dn = 0; rdy = 0;
    for (int i = 0; i < 256; i++) begin
      char_xy = 8'(i);
      tick();
      check($sformatf("sweep[%02h]", i), char_code, 8'(i & 15));
      if (cmd_done) dn++;
      if (cmd_ready) rdy++;
    end
    n = 0;
    while (!cmd_ready && n < 1000) begin
      tick(); n++;
      if (cmd_done && !cmd_ready) dn++;
    end
    cmd_valid = 1'b0;
    check("sweep_ready_low", rdy, 0);
    check("sweep_early_done", dn, 0);
    check("sweep_rest", n, 240);
    check("sweep_done", cmd_done, 1'b1);
    tick();
    check("sweep_no_queue", cmd_done, 1'b0);
    for (int i = 0; i < 256; i++)
      rd(8'(i), ((i >> 4) < 15) ? 8'(i & 15) : 8'h20, "post_sweep");

    // rst after 100 cells of a CLEAR
    for (int i = 0; i < 256; i++) cmd(2'd0, 8'(i), 8'(i));
    cmd(2'd1, 8'h00, 8'h00);
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_char_code", char_code, 8'h00);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_done", cmd_done, 1'b0);
    tick(); tick();
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 300; i++) begin tick(); if (cmd_done) dn++; end
    check("abort_no_done", dn, 0);
    check("abort_idle", cmd_ready, 1'b1);
    for (int i = 0; i < 256; i++) rd(8'(i), (i < 100) ? 8'h20 : 8'(i), "abort");

    // small instance: 4 columns x 2 lines
    s_cmd(2'd1, 8'h00, 8'h00);
    s_wait_idle(n);
    check("s_clear_busy", n, 8);
    check("s_clear_done", s_cmd_done, 1'b1);
    for (int i = 0; i < 8; i++) s_rd({4'(i >> 2), 4'(i & 3)}, 8'h20, "s_clear");
    s_cmd(2'd0, 8'h05, 8'h55);
    check("s_oor_col_done", s_cmd_done, 1'b1);
    tick();
    check("s_oor_col_once", s_cmd_done, 1'b0);
    s_rd(8'h01, 8'h20, "s_oor_col");
    s_cmd(2'd0, 8'h23, 8'h66);
    check("s_oor_line_done", s_cmd_done, 1'b1);
    s_rd(8'h03, 8'h20, "s_oor_line");
    s_rd(8'h13, 8'h20, "s_oor_line");
    for (int i = 0; i < 4; i++) s_cmd(2'd0, 8'(i), 8'(i + 1));
    for (int i = 0; i < 4; i++) s_cmd(2'd0, 8'(8'h10 + i), 8'(8'hA0 + i));
    s_cmd(2'd2, 8'h00, 8'h00);
    s_wait_idle(n);
    check("s_scroll_busy", n, 12);
    check("s_scroll_done", s_cmd_done, 1'b1);
    for (int i = 0; i < 4; i++) s_rd(8'(i), 8'(8'hA0 + i), "s_scroll_l0");
    for (int i = 0; i < 4; i++) s_rd(8'(8'h10 + i), 8'h20, "s_scroll_l1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
